// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: cause codes, FSM states and
// the interrupt-priority helper.
package trap_ctrl_pkg;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        TRAP_REQ,
        TRAP_WAIT,
        MRET_REQ,
        MRET_WAIT,
        REDIRECT
    } trap_state_type;

    // Cause fields carried to the CSR file; eint becomes mcause[31].
    typedef struct packed {
        logic [3:0] ecause;
        logic       eint;
    } trap_cause_type;

    // pending is {meip, mtip, msip}; external beats software beats timer.
    function automatic trap_cause_type irq_cause(input logic [2:0] pending);
        trap_cause_type c;
        c.eint = 1'b1;
        if (pending[2]) begin
            c.ecause = CAUSE_MEI;
        end else if (pending[0]) begin
            c.ecause = CAUSE_MSI;
        end else begin
            c.ecause = CAUSE_MTI;
        end
        return c;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Level synchroniser for one asynchronous interrupt line, STAGES flops deep.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap/mret initiator: arbitrates exceptions, mret and interrupts, hands the
// request to the CSR file, waits for its acknowledge and redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] npc,
    input  logic            exc_req,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_req,
    input  logic            ext_irq,
    input  logic            tim_irq,
    input  logic            sw_irq,
    input  logic            mstatus_mie,
    input  logic [2:0]      mie_en,
    input  logic            csr_exc_ack,
    input  logic            csr_mret_ack,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            csr_exception,
    output logic [XLEN-1:0] csr_epc,
    output logic [3:0]      csr_ecause,
    output logic            csr_eint,
    output logic [XLEN-1:0] csr_etval,
    output logic            csr_mret,
    output logic [2:0]      mip_o,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_type  state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    trap_cause_type  cause_q, cause_d;
    logic [2:0]      pending;

    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .clk_i (clk), .rst_ni(rst), .d_i(ext_irq), .q_o(mip_o[2])
    );
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tim (
        .clk_i (clk), .rst_ni(rst), .d_i(tim_irq), .q_o(mip_o[1])
    );
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw (
        .clk_i (clk), .rst_ni(rst), .d_i(sw_irq), .q_o(mip_o[0])
    );

    assign pending = mip_o & mie_en & {3{mstatus_mie}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            tval_q  <= '0;
            rpc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            rpc_q   <= rpc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        rpc_d   = rpc_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (exc_req) begin
                    epc_d          = pc;
                    tval_d         = exc_tval;
                    cause_d.ecause = exc_cause;
                    cause_d.eint   = 1'b0;
                    state_d        = TRAP_REQ;
                end else if (mret_req) begin
                    state_d = MRET_REQ;
                end else if (valid && (pending != 3'b000)) begin
                    // Interrupt resumes at the next sequential instruction.
                    epc_d   = npc;
                    tval_d  = '0;
                    cause_d = irq_cause(pending);
                    state_d = TRAP_REQ;
                end
            end
            TRAP_REQ: state_d = TRAP_WAIT;
            TRAP_WAIT: begin
                if (csr_exc_ack) begin
                    rpc_d   = csr_mtvec;
                    state_d = REDIRECT;
                end
            end
            MRET_REQ: state_d = MRET_WAIT;
            MRET_WAIT: begin
                if (csr_mret_ack) begin
                    rpc_d   = csr_mepc;
                    state_d = REDIRECT;
                end
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign csr_exception = (state_q == TRAP_REQ);
    assign csr_mret      = (state_q == MRET_REQ);
    assign redirect      = (state_q == REDIRECT);
    assign stall         = (state_q != IDLE);
    assign csr_epc       = epc_q;
    assign csr_etval     = tval_q;
    assign csr_ecause    = cause_q.ecause;
    assign csr_eint      = cause_q.eint;
    assign redirect_pc   = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomised bench for trap_ctrl against a transaction-timeline model.
module tb_trap_ctrl;

    localparam int XLEN = 32;
    localparam int S    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            valid = 1'b0, exc_req = 1'b0, mret_req = 1'b0;
    logic [XLEN-1:0] pc = '0, npc = '0, exc_tval = '0;
    logic [3:0]      exc_cause = '0;
    logic            ext_irq = 1'b0, tim_irq = 1'b0, sw_irq = 1'b0;
    logic            mstatus_mie = 1'b0;
    logic [2:0]      mie_en = '0;
    logic            csr_exc_ack = 1'b0, csr_mret_ack = 1'b0;
    logic [XLEN-1:0] csr_mtvec = '0, csr_mepc = '0;
    logic            csr_exception, csr_eint, csr_mret, stall, redirect;
    logic [XLEN-1:0] csr_epc, csr_etval, redirect_pc;
    logic [3:0]      csr_ecause;
    logic [2:0]      mip_o;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .valid(valid), .pc(pc), .npc(npc),
        .exc_req(exc_req), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .mret_req(mret_req), .ext_irq(ext_irq), .tim_irq(tim_irq),
        .sw_irq(sw_irq), .mstatus_mie(mstatus_mie), .mie_en(mie_en),
        .csr_exc_ack(csr_exc_ack), .csr_mret_ack(csr_mret_ack),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .csr_exception(csr_exception), .csr_epc(csr_epc),
        .csr_ecause(csr_ecause), .csr_eint(csr_eint), .csr_etval(csr_etval),
        .csr_mret(csr_mret), .mip_o(mip_o), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Model: one transaction accepted at posedge m_p with ack delay m_d
    // occupies intervals m_p .. m_p+2+m_d (request, wait, redirect).
    int              cyc = 0;
    int              next_d = 0;
    bit              m_busy = 0, m_mret = 0;
    int              m_p = 0, m_d = 0;
    logic [XLEN-1:0] m_epc = '0, m_tval = '0, m_rpc = '0;
    logic [3:0]      m_cause = '0;
    logic            m_eint = 1'b0;
    logic [2:0]      hist[$];

    function automatic logic [2:0] exp_mip();
        if (hist.size() < S) return 3'b000;
        return hist[0];
    endfunction

    function automatic bit m_idle(input int q);
        return !m_busy || (q >= m_p + 3 + m_d);
    endfunction

    task automatic model_update();
        int q;
        logic [2:0] pend;
        q = cyc + 1;
        pend = exp_mip() & mie_en & {3{mstatus_mie}};
        if (m_idle(cyc)) begin
            if (exc_req) begin
                m_busy = 1; m_mret = 0; m_p = q; m_d = next_d;
                m_epc = pc; m_cause = exc_cause; m_eint = 1'b0; m_tval = exc_tval;
            end else if (mret_req) begin
                m_busy = 1; m_mret = 1; m_p = q; m_d = next_d;
            end else if (valid && pend != 3'b000) begin
                m_busy = 1; m_mret = 0; m_p = q; m_d = next_d;
                m_epc = npc; m_eint = 1'b1; m_tval = '0;
                m_cause = pend[2] ? 4'd11 : (pend[0] ? 4'd3 : 4'd7);
            end
        end else if (cyc == m_p + 1 + m_d) begin
            m_rpc = m_mret ? csr_mepc : csr_mtvec;
        end
        hist.push_back({ext_irq, tim_irq, sw_irq});
        if (hist.size() > S) void'(hist.pop_front());
        cyc = q;
    endtask

    task automatic check_outputs();
        bit seq;
        seq = m_busy && !m_idle(cyc);
        check_eq("csr_exception", csr_exception, seq && !m_mret && cyc == m_p);
        check_eq("csr_mret", csr_mret, seq && m_mret && cyc == m_p);
        check_eq("stall", stall, seq);
        check_eq("redirect", redirect, seq && cyc == m_p + 2 + m_d);
        check_eq("csr_epc", csr_epc, m_epc);
        check_eq("csr_ecause", csr_ecause, m_cause);
        check_eq("csr_eint", csr_eint, m_eint);
        check_eq("csr_etval", csr_etval, m_tval);
        check_eq("redirect_pc", redirect_pc, m_rpc);
        check_eq("mip_o", mip_o, exp_mip());
    endtask

    // CSR stub: acks exactly when the model plans it, sometimes the wrong kind.
    task automatic step();
        csr_exc_ack  = 1'b0;
        csr_mret_ack = 1'b0;
        if (m_busy && cyc == m_p + 1 + m_d) begin
            if (m_mret) csr_mret_ack = 1'b1;
            else        csr_exc_ack  = 1'b1;
        end else if (m_busy && !m_idle(cyc)) begin
            if (m_mret) csr_exc_ack  = ($urandom_range(0, 3) == 0);
            else        csr_mret_ack = ($urandom_range(0, 3) == 0);
        end else begin
            csr_exc_ack  = ($urandom_range(0, 7) == 0);
            csr_mret_ack = ($urandom_range(0, 7) == 0);
        end
        csr_mtvec = $urandom;
        csr_mepc  = $urandom;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_reqs();
        valid = 1'b0; exc_req = 1'b0; mret_req = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        clear_reqs();
        repeat (n) step();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        m_busy = 0; m_epc = '0; m_tval = '0; m_rpc = '0; m_cause = '0; m_eint = 1'b0;
        hist.delete();
        #1 check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        #2 rst = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_outputs();
        #2 rst = 1'b1;

        // Plain exception, ack one cycle after the pulse.
        pc = 32'h100; exc_cause = 4'd2; exc_tval = 32'hDEAD; exc_req = 1'b1; next_d = 0;
        step();
        idle_steps(5);

        // Timer interrupt at a retirement boundary.
        tim_irq = 1'b1; mie_en = 3'b010; mstatus_mie = 1'b1;
        idle_steps(S + 1);
        valid = 1'b1; npc = 32'h204;
        step();
        idle_steps(5);
        mstatus_mie = 1'b0; valid = 1'b1;
        repeat (4) step();
        idle_steps(1);

        // Priority: all three pending, then exception + mret + irq together.
        ext_irq = 1'b1; sw_irq = 1'b1; mie_en = 3'b111; mstatus_mie = 1'b1;
        idle_steps(S + 1);
        valid = 1'b1; npc = 32'h300;
        step();
        idle_steps(5);
        exc_req = 1'b1; mret_req = 1'b1; valid = 1'b1; pc = 32'h180; exc_cause = 4'd5;
        step();
        idle_steps(5);
        mstatus_mie = 1'b0;

        // mret with immediate ack.
        mret_req = 1'b1;
        step();
        idle_steps(5);

        // Withheld acknowledge.
        exc_req = 1'b1; pc = 32'h140; next_d = 10;
        step();
        idle_steps(16);

        // Reset while waiting for the acknowledge.
        exc_req = 1'b1; pc = 32'h150; next_d = 3;
        step();
        idle_steps(2);
        do_reset();
        idle_steps(6);

        for (int i = 0; i < 3000; i++) begin
            valid       = ($urandom_range(0, 1) == 1);
            exc_req     = ($urandom_range(0, 7) == 0);
            mret_req    = ($urandom_range(0, 9) == 0);
            pc          = $urandom;
            npc         = $urandom;
            exc_tval    = $urandom;
            exc_cause   = 4'($urandom_range(0, 15));
            next_d      = ($urandom_range(0, 15) == 0) ? 10 : int'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(0, 15) == 0) tim_irq = ~tim_irq;
            if ($urandom_range(0, 15) == 0) sw_irq  = ~sw_irq;
            if ($urandom_range(0, 31) == 0) mie_en  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) mstatus_mie = ~mstatus_mie;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Initiator side of the CSR trap interface: decides when the core takes a trap or executes mret.
- Drives exception/epc/ecause/etval/mret requests into the CSR file, waits for its registered acknowledge, then redirects fetch to the returned mtvec/mepc.
- Owns interrupt synchronisation, masking and priority.
- Sits between the execute/writeback stage, the CSR file and the fetch stage.

Parameters:
- XLEN, 32, datapath/PC width.
- SYNC_STAGES, 2, flops in each interrupt-input synchroniser (min 2).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- valid  in  1  an instruction retires this cycle.
- pc  in  XLEN  PC of the retiring/faulting instruction.
- npc  in  XLEN  PC of the next sequential instruction.
- exc_req  in  1  synchronous exception on the instruction at pc.
- exc_cause  in  4  exception cause code.
- exc_tval  in  XLEN  trap value.
- mret_req  in  1  mret retiring.
- ext_irq  in  1  external interrupt level, asynchronous.
- tim_irq  in  1  timer interrupt level, asynchronous.
- sw_irq  in  1  software interrupt level, asynchronous.
- mstatus_mie  in  1  global interrupt enable from the CSR file.
- mie_en  in  3  {meie, mtie, msie} from the CSR file.
- csr_exc_ack  in  1  registered exception output of the CSR file.
- csr_mret_ack  in  1  registered mret output of the CSR file.
- csr_mtvec  in  XLEN  trap target from the CSR file.
- csr_mepc  in  XLEN  return target from the CSR file.
- csr_exception  out  1  trap request, one-cycle pulse.
- csr_epc  out  XLEN  epc for the CSR file.
- csr_ecause  out  4  cause for the CSR file.
- csr_eint  out  1  interrupt flag, written as mcause[31].
- csr_etval  out  XLEN  tval for the CSR file.
- csr_mret  out  1  mret request, one-cycle pulse.
- mip_o  out  3  synchronised {meip, mtip, msip} for the mip update.
- stall  out  1  freeze the pipeline.
- redirect  out  1  load redirect_pc into fetch, one-cycle pulse.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; synchronisers cleared; every output 0 immediately. This also applies mid-sequence; a partially issued request is dropped.
- Synchronisers: each irq passes through SYNC_STAGES flops; mip_o equals the synchroniser outputs.
- pending = mip_o & mie_en & {3{mstatus_mie}}.
- States: IDLE, TRAP_REQ, TRAP_WAIT, MRET_REQ, MRET_WAIT, REDIRECT.
- IDLE, arbitration, highest priority first:
  - exc_req=1: latch epc=pc, ecause=exc_cause, eint=0, tval=exc_tval; go to TRAP_REQ. Also wins over a simultaneous mret_req.
  - mret_req=1: go to MRET_REQ.
  - valid=1 and pending!=0: latch epc=npc, eint=1, tval=0; ecause by priority: external=11, then software=3, then timer=7. Go to TRAP_REQ.
  - Interrupts are taken only at a retirement boundary (valid=1).
- TRAP_REQ:
  - csr_exception=1 for exactly this cycle; csr_epc/ecause/eint/etval hold the latched values.
  - stall=1; go to TRAP_WAIT.
- TRAP_WAIT:
  - stall=1.
  - On csr_exc_ack=1: capture csr_mtvec into redirect_pc (the CSR's mcause has updated by then, so vectored mode is correct); go to REDIRECT.
  - Without ack: remain in TRAP_WAIT indefinitely.
- MRET_REQ:
  - csr_mret=1 for exactly this cycle; stall=1; go to MRET_WAIT.
- MRET_WAIT:
  - stall=1.
  - On csr_mret_ack=1: capture csr_mepc into redirect_pc; go to REDIRECT.
- REDIRECT:
  - redirect=1 and stall=1 for one cycle; go to IDLE.
  - redirect_pc holds its value until the next capture.
- Latency: request accepted in cycle N; CSR pulse in N+1; ack in N+2; redirect in N+3; IDLE in N+4.
- Outside IDLE: valid, exc_req, mret_req and irq changes are ignored for arbitration. Synchronisers keep running. A pending interrupt is re-evaluated in IDLE; no re-entry, because the CSR clears MIE.
- Outputs: all registered from state and latched data; no combinational input-to-output paths.

Decomposition:
- Shared package constants: cause codes (CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11); trap_state_type enum.
- Shared package typedefs: trap_in_type / trap_out_type structs alongside the CSR structs.
- CSR in-struct gains eint.
- One sub-module: irq_sync, a parameterised SYNC_STAGES-deep synchroniser, instantiated three times.

Test Plan:
- Exception, no interrupts:
  - Stimulus: exc_req=1, pc=0x100, exc_cause=2, exc_tval=0xDEAD; ack looped back one cycle later; csr_mtvec=0x400.
  - Response: csr_exception pulses with epc=0x100, ecause=2, eint=0, etval=0xDEAD; redirect=1, redirect_pc=0x400 three cycles after the request.
- Timer interrupt:
  - Stimulus: tim_irq=1, mie_en=3'b010, mstatus_mie=1, valid=1 with npc=0x204.
  - Response: trap ecause=7, eint=1, epc=0x204.
  - Repeat with mstatus_mie=0: no trap.
- Priority:
  - Stimulus: all three irqs high and enabled.
  - Response: ecause=11.
  - Then exc_req plus mret_req plus irq in the same cycle: exception taken, no csr_mret.
- mret:
  - Stimulus: mret_req=1; csr_mepc=0x208.
  - Response: csr_mret pulse; redirect_pc=0x208; stall high from N+1 to N+3.
- Stalled ack: withhold csr_exc_ack for 10 cycles → stall held, redirect=0, csr_exception not re-pulsed.
- Reset during TRAP_WAIT: rst=0 → all outputs 0 asynchronously, IDLE after release, no redirect.
